// File: rtl/alu_shift_seq_pkg.sv
// Shared types, opcode codes and helpers for the multi-cycle shift sequencer.
// The ALU shifts one bit per pass; the sequencer iterates it for larger amounts.
package alu_shift_seq_pkg;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_SHAMT_W   = $clog2(DEF_WORD_SIZE);

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 4'd0;
    localparam alu_op_t ALU_SUB = 4'd1;
    localparam alu_op_t ALU_AND = 4'd2;
    localparam alu_op_t ALU_OR  = 4'd3;
    localparam alu_op_t ALU_NOR = 4'd4;
    localparam alu_op_t ALU_XOR = 4'd5;
    localparam alu_op_t ALU_SLL = 4'd6;
    localparam alu_op_t ALU_SRL = 4'd7;
    localparam alu_op_t ALU_SRA = 4'd8;
    localparam alu_op_t ALU_SLA = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input alu_op_t op);
        case (op)
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLA: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_valid_op(input alu_op_t op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR: return 1'b1;
            default:                                             return is_shift_op(op);
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_seq_if.sv
// Request/response handshake bundle between issue, the sequencer and writeback.
interface alu_shift_seq_if #(
    parameter int WORD_SIZE = 32,
    parameter int SHAMT_W   = 5
);
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_op;
    logic [WORD_SIZE-1:0] req_a;
    logic [WORD_SIZE-1:0] req_b;
    logic [SHAMT_W-1:0]   req_shamt;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_data;
    logic                 rsp_zero;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_shift_seq_alu.sv
// Shared single-cycle ALU; shift opcodes move the operand by exactly one bit.
// Undefined opcodes produce zero so no X can escape downstream.
module alu
    import alu_shift_seq_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] in_1,
    input  logic [WORD_SIZE-1:0] in_2,
    input  alu_op_t              op,
    output logic [WORD_SIZE-1:0] out
);

    // Opcode decode and single-bit shift datapath.
    always_comb begin
        out = '0;
        case (op)
            ALU_ADD:          out = in_1 + in_2;
            ALU_SUB:          out = in_1 - in_2;
            ALU_AND:          out = in_1 & in_2;
            ALU_OR:           out = in_1 | in_2;
            ALU_NOR:          out = ~(in_1 | in_2);
            ALU_XOR:          out = in_1 ^ in_2;
            ALU_SLL, ALU_SLA: out = {in_1[WORD_SIZE-2:0], 1'b0};
            ALU_SRL:          out = {1'b0, in_1[WORD_SIZE-1:1]};
            ALU_SRA:          out = {in_1[WORD_SIZE-1], in_1[WORD_SIZE-1:1]};
            default:          out = '0;
        endcase
    end

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-cycle sequencer in front of the shared ALU: iterates one-bit shifts
// until the requested amount is reached; other ops complete in one cycle.
module alu_shift_seq
    import alu_shift_seq_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int SHAMT_W   = $clog2(WORD_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_shift_seq_if.slave bus,
    output logic          busy
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t               state_r, state_nx_s;
    logic [WORD_SIZE-1:0] acc_r, acc_nx_s;
    logic [SHAMT_W-1:0]   cnt_r, cnt_nx_s;
    alu_op_t              op_r, op_nx_s;
    logic                 err_r, err_nx_s;
    logic                 zero_r, valid_r, ready_r, busy_r;
    logic [WORD_SIZE-1:0] alu_in1_s, alu_in2_s, alu_out_s;
    alu_op_t              alu_op_s;

    // ALU operand mux: live request while idle, accumulator while iterating.
    always_comb begin
        if (state_r == ST_SHIFT) begin
            alu_in1_s = acc_r;
            alu_in2_s = '0;
            alu_op_s  = op_r;
        end else begin
            alu_in1_s = bus.req_a;
            alu_in2_s = bus.req_b;
            alu_op_s  = bus.req_op;
        end
    end

    alu #(.WORD_SIZE(WORD_SIZE)) u_alu (
        .in_1 (alu_in1_s),
        .in_2 (alu_in2_s),
        .op   (alu_op_s),
        .out  (alu_out_s)
    );

    // Next-state and datapath update decisions.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        cnt_nx_s   = cnt_r;
        op_nx_s    = op_r;
        err_nx_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_nx_s  = bus.req_op;
                    err_nx_s = 1'b0;
                    if (is_shift_op(bus.req_op)) begin
                        if (bus.req_shamt == '0) begin
                            acc_nx_s   = bus.req_a;
                            state_nx_s = ST_DONE;
                        end else begin
                            acc_nx_s   = alu_out_s;
                            cnt_nx_s   = bus.req_shamt - CNT_ONE;
                            state_nx_s = (bus.req_shamt == CNT_ONE) ? ST_DONE : ST_SHIFT;
                        end
                    end else if (is_valid_op(bus.req_op)) begin
                        acc_nx_s   = alu_out_s;
                        state_nx_s = ST_DONE;
                    end else begin
                        acc_nx_s   = '0;
                        err_nx_s   = 1'b1;
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_nx_s = alu_out_s;
                cnt_nx_s = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake/status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            op_r    <= ALU_ADD;
            err_r   <= 1'b0;
            zero_r  <= 1'b0;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            cnt_r   <= cnt_nx_s;
            op_r    <= op_nx_s;
            err_r   <= err_nx_s;
            // Zero flag follows the stored result, never the ALU's own flag.
            zero_r  <= (state_nx_s == ST_DONE) && !err_nx_s && (acc_nx_s == '0);
            valid_r <= (state_nx_s == ST_DONE);
            ready_r <= (state_nx_s == ST_IDLE);
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_data  = acc_r;
    assign bus.rsp_zero  = zero_r;
    assign bus.rsp_err   = err_r;
    assign busy          = busy_r;

endmodule

// File: doc/alu_shift_seq.md
Name: alu_shift_seq

Overview:
Multi-cycle sequencer in front of the shared ALU.
- The ALU shifts by exactly one bit per pass. This block accepts a request with an arbitrary shift amount and iterates the ALU once per cycle until done.
- Non-shift operations pass through in a single registered cycle.
- Sits between decode/issue and writeback. Uses valid/ready handshakes on both request and response sides.

Parameters:
- WORD_SIZE, default `WORD_SIZE (32): datapath width.
- SHAMT_W, default 5: shift-amount width. Equals $clog2(WORD_SIZE).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  ALU opcode (`ALU_* from definitions.v)
- req_a  in  WORD_SIZE  operand 1; the value to shift for shift ops
- req_b  in  WORD_SIZE  operand 2; ignored for shift ops
- req_shamt  in  SHAMT_W  shift amount; ignored for non-shift ops
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  WORD_SIZE  result
- rsp_zero  out  1  rsp_data == 0
- rsp_err  out  1  unsupported opcode
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, any state including mid-shift):
  - State goes to IDLE; acc and cnt are cleared.
  - rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_err=0, busy=0, req_ready=1 after reset.
  - An in-flight operation is discarded; no response is produced.
- States:
  - IDLE: req_ready=1.
  - SHIFT: iterating.
  - DONE: rsp_valid=1.
- Accept rule: a request is accepted on a clock edge where req_valid && req_ready. req_ready=1 only in IDLE, so there is at most one operation in flight.
- ALU input mux:
  - IDLE: in_1=req_a, in_2=req_b, op=req_op.
  - SHIFT: in_1=acc, in_2=0, op=latched op.
- Shift ops are `ALU_SLL, `ALU_SRL, `ALU_SRA and `ALU_SLA. `ALU_SLA is identical to `ALU_SLL.
- IDLE accept, shift op with shamt > 0: latch op; acc <= alu_out (first bit shifted); cnt <= shamt-1. If cnt would be 0, go to DONE; else go to SHIFT.
- IDLE accept, shift op with shamt == 0: result <= req_a, no ALU use; go to DONE.
- IDLE accept, non-shift defined op (ADD/SUB/AND/OR/NOR/XOR): result <= alu_out; go to DONE.
- IDLE accept, undefined opcode: result <= 0, rsp_err=1, rsp_zero=0; go to DONE. X from the ALU must never reach rsp_data.
- SHIFT: each cycle acc <= alu_out and cnt <= cnt-1. When cnt == 1, go to DONE with the updated acc as the result.
- Latency, for acceptance at edge T:
  - rsp_valid rises after edge T+max(1,N) for a shift with N = shamt.
  - rsp_valid rises after edge T+1 for all other ops.
  - Maximum latency is 31 cycles.
- DONE:
  - rsp_data, rsp_zero and rsp_err are stable while rsp_valid=1 && !rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. The next request can be accepted one cycle later; there is no same-cycle turnaround.
- rsp_zero is computed from the registered result, not taken from the ALU zero output.
- rsp_err is cleared when the next operation is accepted.
- req_* inputs are sampled only at acceptance. Changes during SHIFT or DONE are ignored.
- Shift count is bounded by SHAMT_W, so shifting by ≥ WORD_SIZE is impossible.

Decomposition:
- Shared package:
  - state enum (IDLE, SHIFT, DONE);
  - is_shift_op(op) and is_valid_op(op) helper functions over the `ALU_* codes;
  - SHAMT_W derivation.
- One sub-module: instantiate the existing alu, which is the only sub-module. Keep the control FSM and the acc/cnt registers in this module.

Test Plan:
- `ALU_SLL, a=0x00000001, shamt=31 -> rsp_data=0x80000000, zero=0, rsp_valid 31 cycles after accept, busy=1 throughout.
- `ALU_SRA, a=0x80000000, shamt=4 -> 0xF8000000 after 4 cycles; `ALU_SRL same operands -> 0x08000000.
- `ALU_SRL, a=0xF0000000, shamt=0 -> 0xF0000000 after 1 cycle. `ALU_ADD a=5, b=0xFFFFFFFB -> 0x00000000, rsp_zero=1, 1 cycle.
- Backpressure: `ALU_XOR 0xFF00FF00^0x0F0F0F0F with rsp_ready=0 for 3 cycles -> rsp_data holds 0xF00FF00F, req_ready=0, second req_valid not accepted until the handshake completes.
- Undefined opcode -> rsp_err=1, rsp_data=0, rsp_zero=0; the next valid op clears rsp_err.
- rst_n asserted at cycle 3 of a shamt=10 `ALU_SLL -> all outputs 0 immediately (async); after release req_ready=1 and no stale rsp_valid appears.
